// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I kind codes, opcodes and funct fields for the loader
package riscv_pkg;

  localparam logic [3:0] KIND_ADD  = 4'd0;
  localparam logic [3:0] KIND_SUB  = 4'd1;
  localparam logic [3:0] KIND_SLT  = 4'd2;
  localparam logic [3:0] KIND_OR   = 4'd3;
  localparam logic [3:0] KIND_AND  = 4'd4;
  localparam logic [3:0] KIND_ADDI = 4'd5;
  localparam logic [3:0] KIND_LW   = 4'd6;
  localparam logic [3:0] KIND_SW   = 4'd7;
  localparam logic [3:0] KIND_BEQ  = 4'd8;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

endpackage

// File: rtl/instr_loader_encoder_if.sv
// rtl/instr_loader_encoder_if.sv - request and instruction-memory write bus
interface instr_loader_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_kind;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [12:0]       req_imm;
  logic              req_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm, req_last,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_imm, req_last,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - combinational RV32I encoder with legality check
module instr_encode
  import riscv_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [12:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic imm_oor;
  assign imm_oor = imm_i[12] ^ imm_i[11];

  always_comb begin
    word_o    = '0;
    illegal_o = imm_oor;
    case (kind_i)
      KIND_ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_REG};
      KIND_SUB:  word_o = {F7_SUB, rs2_i, rs1_i, F3_ADD_SUB, rd_i, OP_REG};
      KIND_SLT:  word_o = {F7_BASE, rs2_i, rs1_i, F3_SLT, rd_i, OP_REG};
      KIND_OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR, rd_i, OP_REG};
      KIND_AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OP_REG};
      KIND_ADDI: word_o = {imm_i[11:0], rs1_i, F3_ADD_SUB, rd_i, OP_IMM};
      KIND_LW:   word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OP_LOAD};
      KIND_SW:   word_o = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OP_STORE};
      KIND_BEQ: begin
        // Branch offsets use the full 13-bit range but must be halfword aligned.
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                     imm_i[4:1], imm_i[11], OP_BRANCH};
        illegal_o = imm_i[0];
      end
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_loader_encoder.sv
// rtl/instr_loader_encoder.sv - session FSM writing encoded RV32I words into imem
module instr_loader_encoder
  import riscv_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  instr_loader_encoder_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        xfer;
  logic        wr;

  instr_encode u_encode (
    .kind_i    (bus.req_kind),
    .rd_i      (bus.req_rd),
    .rs1_i     (bus.req_rs1),
    .rs2_i     (bus.req_rs2),
    .imm_i     (bus.req_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign bus.req_ready = (state_q == ST_LOAD) && !start;
  assign xfer          = bus.req_valid && bus.req_ready;
  // Once the top word is written the session is full: later requests are consumed as errors.
  assign wr            = xfer && !enc_illegal && !full_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    full_d  = full_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we_d    = wr;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (wr) begin
      waddr_d = addr_q;
      wdata_d = enc_word;
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + 1'b1;
    end
    if (xfer && !wr) err_d = 1'b1;

    case (state_q)
      ST_LOAD:   if (xfer && bus.req_last) state_d = ST_FINISH;
      ST_FINISH: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_IDLE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A restart leaves any already-registered write alone but drops the pending done.
    if (start) begin
      state_d = ST_LOAD;
      addr_d  = BASE;
      full_d  = 1'b0;
      err_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= BASE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      err_q   <= err_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_FINISH);
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_instr_loader_encoder.sv
// tb/tb_instr_loader_encoder.sv - scoreboard bench for instr_loader_encoder
module tb_instr_loader_encoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, va, vb;
  logic [3:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [12:0] imm;
  logic        last;
  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  instr_loader_encoder_if #(.ADDR_W(8)) bus_a ();
  instr_loader_encoder_if #(.ADDR_W(2)) bus_b ();

  assign bus_a.req_valid = va;
  assign bus_a.req_kind  = kind;
  assign bus_a.req_rd    = rd;
  assign bus_a.req_rs1   = rs1;
  assign bus_a.req_rs2   = rs2;
  assign bus_a.req_imm   = imm;
  assign bus_a.req_last  = last;
  assign bus_b.req_valid = vb;
  assign bus_b.req_kind  = kind;
  assign bus_b.req_rd    = rd;
  assign bus_b.req_rs1   = rs1;
  assign bus_b.req_rs2   = rs2;
  assign bus_b.req_imm   = imm;
  assign bus_b.req_last  = last;

  instr_loader_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  instr_loader_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] q_a[$];
  logic [39:0] q_b[$];
  int  exp_addr_a, exp_addr_b;
  bit  full_a, full_b;
  logic [39:0] ea, eb;
  int  w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_a.imem_we === 1'b1) begin
      if (q_a.size() == 0) check("a_unexpected_write", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_waddr", bus_a.imem_addr, ea[39:32]);
        check("a_wdata", bus_a.imem_wdata, ea[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (bus_b.imem_we === 1'b1) begin
      if (q_b.size() == 0) check("b_unexpected_write", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_waddr", bus_b.imem_addr, eb[39:32]);
        check("b_wdata", bus_b.imem_wdata, eb[31:0]);
      end
    end
  end

  task automatic expect_write(input bit s, input logic [31:0] word);
    if (!s) begin
      if (!full_a) begin
        q_a.push_back({8'(exp_addr_a), word});
        if (exp_addr_a == 255) full_a = 1'b1;
        else exp_addr_a++;
      end
    end else begin
      if (!full_b) begin
        q_b.push_back({8'(exp_addr_b), word});
        if (exp_addr_b == 3) full_b = 1'b1;
        else exp_addr_b++;
      end
    end
  endtask

  task automatic pulse_start(input bit s);
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    #1;
    check("ready_during_start", s ? bus_b.req_ready : bus_a.req_ready, 0);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    if (s) begin exp_addr_b = 0; full_b = 1'b0; end
    else   begin exp_addr_a = 0; full_a = 1'b0; end
    #1;
    check("busy_after_start", s ? busy_b : busy_a, 1);
    check("err_after_start", s ? err_b : err_a, 0);
  endtask

  task automatic send(input bit s, input logic [3:0] k, input logic [4:0] d,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [12:0] im,
                      input bit l, input bit legal, input logic [31:0] word,
                      output int waited);
    kind = k; rd = d; rs1 = r1; rs2 = r2; imm = im; last = l;
    if (s) vb = 1'b1; else va = 1'b1;
    #1;
    waited = 0;
    while (!(s ? bus_b.req_ready : bus_a.req_ready) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 0, 1);
    else if (legal) expect_write(s, word);
    @(negedge clk);
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic wait_done(input bit s, input string tag);
    int c;
    c = 0;
    while (!(s ? done_b : done_a) && c < 10) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(tag, s ? done_b : done_a, 1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; va = 1'b0; vb = 1'b0;
    kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0;
    exp_addr_a = 0; exp_addr_b = 0; full_a = 1'b0; full_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", bus_a.req_ready, 0);
    check("rst_we", bus_a.imem_we, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_addr", bus_a.imem_addr, 0);
    check("rst_wdata", bus_a.imem_wdata, 0);
    check("rst_b_busy", busy_b, 0);
    @(negedge clk);
    rst = 1'b0;

    // single ADD with last: write next cycle, done one cycle after that
    pulse_start(0);
    send(0, KIND_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1, 1, 32'h002081B3, w);
    #1;
    check("t1_we", bus_a.imem_we, 1);
    check("t1_ready_finish", bus_a.req_ready, 0);
    check("t1_busy_finish", busy_a, 1);
    check("t1_done_early", done_a, 0);
    @(negedge clk); #1;
    check("t1_done", done_a, 1);
    check("t1_busy_drop", busy_a, 0);
    @(negedge clk); #1;
    check("t1_done_pulse", done_a, 0);

    // back-to-back stream, then aligned and misaligned BEQ
    pulse_start(0);
    send(0, KIND_SUB, 5'd5, 5'd6, 5'd7, 13'd0, 0, 1, 32'h407302B3, w);
    check("t2_sub_wait", w, 0);
    send(0, KIND_ADDI, 5'd1, 5'd0, 5'd0, 13'h1FFF, 0, 1, 32'hFFF00093, w);
    check("t2_addi_wait", w, 0);
    send(0, KIND_LW, 5'd2, 5'd1, 5'd0, 13'd8, 0, 1, 32'h0080A103, w);
    check("t2_lw_wait", w, 0);
    send(0, KIND_SW, 5'd0, 5'd1, 5'd2, 13'd12, 0, 1, 32'h0020A623, w);
    check("t2_sw_wait", w, 0);
    send(0, KIND_BEQ, 5'd0, 5'd1, 5'd2, 13'h1FFC, 0, 1, 32'hFE208EE3, w);
    #1;
    check("t2_err_clear", err_a, 0);
    send(0, KIND_BEQ, 5'd0, 5'd1, 5'd2, 13'd3, 1, 0, 32'h0, w);
    #1;
    check("t2_beq_odd_err", err_a, 1);
    check("t2_beq_odd_we", bus_a.imem_we, 0);
    check("t2_addr_hold", bus_a.imem_addr, 4);
    wait_done(0, "t2_done");

    // illegal kind and out-of-range immediate are consumed without writes
    pulse_start(0);
    send(0, 4'd12, 5'd1, 5'd1, 5'd1, 13'd0, 0, 0, 32'h0, w);
    #1;
    check("t3_kind_err", err_a, 1);
    send(0, KIND_ADDI, 5'd1, 5'd0, 5'd0, 13'h0800, 0, 0, 32'h0, w);
    send(0, KIND_ADD, 5'd3, 5'd1, 5'd2, 13'd0, 1, 1, 32'h002081B3, w);
    wait_done(0, "t3_done");
    check("t3_err_sticky", err_a, 1);
    pulse_start(0);

    // small memory: fifth write is dropped once the top word is used
    pulse_start(1);
    for (int i = 0; i < 5; i++)
      send(1, KIND_ADD, 5'd3, 5'd1, 5'd2, 13'd0, i == 4, 1, 32'h002081B3, w);
    #1;
    check("t4_full_err", err_b, 1);
    wait_done(1, "t4_done");
    pulse_start(1);
    send(1, KIND_OR, 5'd4, 5'd2, 5'd3, 13'd0, 1, 1, 32'h00316233, w);
    wait_done(1, "t4_restart_done");

    // reset with a write on the bus, which also exercises start during LOAD
    pulse_start(0);
    send(0, KIND_AND, 5'd4, 5'd2, 5'd3, 13'd0, 1, 1, 32'h00317233, w);
    #1;
    check("t5_we_before_rst", bus_a.imem_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_we", bus_a.imem_we, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_ready", bus_a.req_ready, 0);
    check("t5_rst_addr", bus_a.imem_addr, 0);
    @(negedge clk); #1;
    check("t5_rst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_post_done", done_a, 0);
    check("t5_post_busy", busy_a, 0);
    check("t5_post_we", bus_a.imem_we, 0);

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader_encoder.md
# instr_loader_encoder

Encodes structured instruction requests (operation kind, register indices, immediate) into 32-bit RV32I words. It then writes them sequentially into the instruction memory through a registered write port. It is the producer side of the core's instruction decode: it emits exactly the R-type ADD/SUB/SLT/OR/AND, ADDI, LW, SW and BEQ encodings that the control path decodes. It sits between the test/boot host and the instruction memory write port.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width.
- `BASE_ADDR`, default 0: first word address of every load session.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that opens or restarts a load session.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block accepts a request this cycle.
- `req_kind` in 4: 0 ADD, 1 SUB, 2 SLT, 3 OR, 4 AND, 5 ADDI, 6 LW, 7 SW, 8 BEQ; 9–15 are illegal.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register indices; unused fields are ignored.
- `req_imm` in 13: signed immediate. It is the byte offset for BEQ and a 12-bit value sign-extended to 13 bits for the other kinds.
- `req_last` in 1: marks the final request of the session.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: write word address.
- `imem_wdata` out 32: encoded instruction.
- `busy` out 1: a session is active.
- `done` out 1: one-cycle pulse when the session completes.
- `err` out 1: sticky error, cleared by `start`.

## Operation
- FSM states:
  - IDLE → LOAD on `start`.
  - LOAD → FINISH on an accepted request with `req_last`.
  - FINISH → IDLE after one cycle.
- `start` has priority in every state. It enters LOAD, sets the address counter to BASE_ADDR, clears `err` and clears the full flag.
- `req_ready` = (state == LOAD) and no `start` this cycle. A transfer is `req_valid & req_ready`.
- `busy` = state is LOAD or FINISH.
- Encoding, with fields in standard RV32I positions:
  - R-type: funct7|rs2|rs1|funct3|rd|0110011.
    - ADD: f7 0000000, f3 000.
    - SUB: f7 0100000, f3 000.
    - SLT: f7 0000000, f3 010.
    - OR: f7 0000000, f3 110.
    - AND: f7 0000000, f3 111.
  - ADDI: imm[11:0]|rs1|000|rd|0010011.
  - LW: imm[11:0]|rs1|010|rd|0000011.
  - SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
  - BEQ: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11]|1100011.
- A request is illegal when any of these holds:
  - `req_kind` ≥ 9.
  - Non-BEQ kind with imm[12] ≠ imm[11] (out of range).
  - BEQ with imm[0] = 1.
  - The full flag is set.
- Illegal requests are still consumed. They produce no write, do not advance the address, and set `err`. A `req_last` on an illegal request still ends the session.
- Full flag: set when a write occurs at address 2^ADDR_W−1. The address does not wrap, and every later request in the session is illegal.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`, `imem_we`, `busy`, `done`, `err` all 0.
  - `imem_addr` = BASE_ADDR.
  - `imem_wdata` = 0.
- Write latency is 1 cycle. A legal transfer in cycle N gives `imem_we`=1 in N+1, with `imem_addr` and `imem_wdata` registered. The counter increments at the end of N.
- Throughput is one request per cycle in LOAD.
- Last request accepted in N:
  - The write (if legal) occurs in N+1, in state FINISH, with `req_ready`=0.
  - `done`=1 in N+2 and the state returns to IDLE.
- A `start` during LOAD or FINISH does not cancel a write already registered from the previous cycle. It suppresses the pending `done`.
- An asynchronous `rst` mid-session aborts immediately. Outputs take their reset values and no further write is issued.

## Structure
- Package `riscv_pkg` holds:
  - The kind codes.
  - The opcodes (0110011, 0010011, 0000011, 0100011, 1100011).
  - The funct3/funct7 constants.
- One combinational sub-module, `instr_encode`: inputs kind, rd, rs1, rs2 and imm; outputs a 32-bit word and an illegal flag.
- The FSM, address counter, full flag and output registers live in the top level.

## Test plan
- `start`, then ADD rd3 rs1=1 rs2=2 with `req_last` → write 0x002081B3 at address 0 one cycle later; `done` two cycles after acceptance; `busy` drops.
- Back-to-back SUB 5,6,7 / ADDI 1,0,−1 / LW 2,8(1) / SW x2,12(x1) with `req_valid` held → words 0x407302B3, 0xFFF00093, 0x0080A103, 0x0020A623 at addresses 0–3 on consecutive cycles.
- BEQ rs1=1 rs2=2 imm=−4 → 0xFE208EE3. BEQ with imm=3 → no write, `err`=1, address unchanged.
- `req_kind`=12, then ADDI with imm=0x800 (out of range), then a legal ADD → only the ADD is written, at BASE_ADDR; `err` stays 1 until the next `start`.
- ADDR_W=2: five legal requests → addresses 0–3 written, fifth dropped with `err`=1; `start` then clears `err` and restarts at address 0.
- `rst` asserted mid-stream with a write pending → `imem_we`=0 immediately; no `done`; state IDLE.
